instr_mem: RTL and testbench
============================

Name: instr_mem

Overview:
Parametrised, writable successor to the fixed 256x21 instruction ROM.
- Instruction store with one-cycle synchronous fetch and a fetch-valid flag.
- Program-load mode through which the host writes the program image.
- Hardware fill sweep after reset, so every unloaded location holds the default trap/jump word.
- Sits between the C0 program counter/fetch stage and the programming interface.

Parameters:
DATA_W, 21, instruction width in bits
ADDR_W, 8, address width
DEPTH, 256, implemented words (1..2**ADDR_W); addresses >= DEPTH are out of range
FILL_WORD, 21'h1C0009, word written by the clear sweep and returned for out-of-range fetches
CLEAR_ON_RESET, 1, 1 = run the fill sweep after reset; 0 = go straight to RUN

Ports:
CLK  in  1  clock
RST_N  in  1  synchronous active-low reset, sampled on the rising edge of CLK
FETCH_REQ  in  1  fetch request, honoured only in RUN
FETCH_ADDR  in  ADDR_W  fetch address
INSTRUCTION  out  DATA_W  fetched word, registered
FETCH_VALID  out  1  INSTRUCTION updated by a fetch issued on the previous cycle
READY  out  1  high in RUN only
PROG_MODE  in  1  level request to enter or stay in program-load mode
LOAD_WE  in  1  write strobe, honoured only in PROG
LOAD_ADDR  in  ADDR_W  write address
LOAD_DATA  in  DATA_W  write data
LOAD_COUNT  out  ADDR_W+1  in-range writes accepted in the current or most recent PROG session, saturating

Behaviour:
- Reset (RST_N=0 at an edge):
  - State = CLEAR if CLEAR_ON_RESET=1, else RUN.
  - Clear pointer = 0, INSTRUCTION = FILL_WORD, FETCH_VALID = 0, READY = 0, LOAD_COUNT = 0.
  - Reset mid-sweep or mid-load aborts the operation immediately. Array contents are not reset; only the sweep rewrites them.
- CLEAR:
  - Each cycle writes FILL_WORD to mem[ptr], then ptr++.
  - After writing DEPTH-1, next state is RUN if PROG_MODE=0, else PROG. Sweep length is exactly DEPTH cycles.
  - FETCH_REQ, LOAD_WE and PROG_MODE are ignored until the final cycle.
- RUN:
  - READY = 1.
  - FETCH_REQ=1 at edge t gives INSTRUCTION = mem[FETCH_ADDR], or FILL_WORD if FETCH_ADDR >= DEPTH, with FETCH_VALID=1 after edge t+1.
  - Back-to-back requests give one result per cycle.
  - With no request, FETCH_VALID = 0 and INSTRUCTION holds its last value.
  - PROG_MODE=1 sampled at an edge moves to PROG next cycle. A FETCH_REQ in that same cycle is still served.
- PROG:
  - READY = 0, FETCH_VALID = 0, FETCH_REQ ignored, INSTRUCTION holds.
  - LOAD_COUNT clears to 0 on the entry cycle.
  - LOAD_WE=1 with LOAD_ADDR < DEPTH writes LOAD_DATA and increments LOAD_COUNT, saturating at 2**(ADDR_W+1)-1.
  - LOAD_WE with an out-of-range address is dropped and not counted.
  - Rewriting the same address overwrites it and counts again.
  - PROG_MODE=0 sampled at an edge returns to RUN. A LOAD_WE in that same cycle is still performed and counted.
  - LOAD_COUNT holds after exit until the next PROG entry.
- Read-after-write: a fetch issued the cycle after the RUN re-entry edge sees all writes.
- No simultaneous read and write to the array occurs; the state machine guarantees mutual exclusion.
- Latency: fetch 1 cycle; write visible on the next cycle.

Decomposition:
- Shared package c0_imem_pkg:
  - state enum {CLEAR, RUN, PROG}
  - default DATA_W / ADDR_W
  - C0_FILL_WORD constant = 21'h1C0009
- Sub-module imem_array: DEPTH x DATA_W single-clock RAM with one write port and one registered read port. It holds no control logic.
- The FSM, clear pointer, range checks and counter stay in instr_mem.

Test Plan:
1. Reset with defaults, hold idle: READY rises after exactly 256 CLEAR cycles. Then FETCH_REQ to 0x05 and 0xFF returns 0x1C0009 with FETCH_VALID one cycle later.
2. PROG_MODE=1; write 0x05C000@0x00, 0x060000@0x01, 0x1D8301@0x02; PROG_MODE=0. Expect LOAD_COUNT=3; back-to-back fetches 0,1,2 return those words on consecutive cycles, each with FETCH_VALID=1.
3. In PROG, pulse FETCH_REQ to 0x00: FETCH_VALID stays 0 and INSTRUCTION unchanged. Fetch issued on the PROG_MODE rising cycle is still returned.
4. DEPTH=200: LOAD_WE to 0xC8 is dropped with LOAD_COUNT unchanged; fetch of 0xC8 returns 0x1C0009; write/fetch at 0xC7 round-trips.
5. Assert RST_N=0 mid-load after 2 writes: next cycle state = CLEAR, READY = 0, LOAD_COUNT = 0. After the sweep, address 0x01 reads 0x1C0009.
6. CLEAR_ON_RESET=0: READY=1 one cycle after reset release. PROG_MODE held high throughout the sweep with CLEAR_ON_RESET=1 enters PROG directly after cycle 256, with READY never asserted.

Source files
------------

// File: rtl/c0_imem_pkg.sv
// Shared definitions for the C0 instruction store: default geometry,
// the trap/jump fill word and the controller state encoding.
package c0_imem_pkg;

   localparam int C0_DATA_W = 21;
   localparam int C0_ADDR_W = 8;

   // Default word for unloaded or out-of-range locations (trap/jump).
   localparam logic [C0_DATA_W-1:0] C0_FILL_WORD = 21'h1C0009;

   typedef enum logic [1:0] {
      CLEAR = 2'd0,
      RUN   = 2'd1,
      PROG  = 2'd2
   } imem_state_t;

endpackage

// File: rtl/imem_array.sv
// DEPTH x DATA_W single-clock RAM: one write port and one registered read
// port. Pure storage; all sequencing and range checks live in the parent.
module imem_array
   import c0_imem_pkg::*;
#(
   parameter int DATA_W = C0_DATA_W,
   parameter int ADDR_W = C0_ADDR_W,
   parameter int DEPTH  = 2**C0_ADDR_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   // Write port: the caller only asserts we with an in-range address.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Registered read port; rdata holds between reads.
   always_ff @(posedge clk) begin
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/instr_mem.sv
// Writable C0 instruction store. After reset an optional sweep fills every
// word with FILL_WORD; RUN serves one-cycle fetches; PROG lets the host
// load the program image and counts accepted writes.
module instr_mem
   import c0_imem_pkg::*;
#(
   parameter int                DATA_W         = C0_DATA_W,
   parameter int                ADDR_W         = C0_ADDR_W,
   parameter int                DEPTH          = 2**C0_ADDR_W,
   parameter logic [DATA_W-1:0] FILL_WORD      = C0_FILL_WORD,
   parameter bit                CLEAR_ON_RESET = 1'b1
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic              FETCH_REQ,
   input  logic [ADDR_W-1:0] FETCH_ADDR,
   output logic [DATA_W-1:0] INSTRUCTION,
   output logic              FETCH_VALID,
   output logic              READY,
   input  logic              PROG_MODE,
   input  logic              LOAD_WE,
   input  logic [ADDR_W-1:0] LOAD_ADDR,
   input  logic [DATA_W-1:0] LOAD_DATA,
   output logic [ADDR_W:0]   LOAD_COUNT
);

   localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_PTR  = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   COUNT_MAX = '1;

   imem_state_t       state_reg;
   imem_state_t       state_next;
   logic [ADDR_W-1:0] ptr_reg;
   logic              fill_sel_reg;
   logic              valid_reg;
   logic              ready_reg;
   logic [ADDR_W:0]   count_reg;

   logic              fetch_in_range;
   logic              load_in_range;
   logic              fetch_fire;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_re;
   logic [DATA_W-1:0] mem_rdata;

   assign fetch_in_range = ({1'b0, FETCH_ADDR} < DEPTH_L);
   assign load_in_range  = ({1'b0, LOAD_ADDR} < DEPTH_L);

   // A fetch is accepted only in RUN and never on a reset edge.
   assign fetch_fire = RST_N && (state_reg == RUN) && FETCH_REQ;
   assign mem_re     = fetch_fire && fetch_in_range;

   // Next-state: the sweep ends after the last word; PROG_MODE steers RUN/PROG.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         CLEAR:   if (ptr_reg == LAST_PTR) state_next = PROG_MODE ? PROG : RUN;
         RUN:     if (PROG_MODE) state_next = PROG;
         PROG:    if (!PROG_MODE) state_next = RUN;
         default: state_next = RUN;
      endcase
   end

   // Single write port shared by the fill sweep and host loads; a reset edge
   // suppresses any write so an interrupted operation leaves no trace.
   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = ptr_reg;
      mem_wdata = FILL_WORD;
      if (RST_N) begin
         case (state_reg)
            CLEAR: mem_we = 1'b1;
            PROG: begin
               if (LOAD_WE && load_in_range) begin
                  mem_we    = 1'b1;
                  mem_waddr = LOAD_ADDR;
                  mem_wdata = LOAD_DATA;
               end
            end
            default: mem_we = 1'b0;
         endcase
      end
   end

   // Controller state, sweep pointer, fetch status and load counter.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_reg    <= CLEAR_ON_RESET ? CLEAR : RUN;
         ptr_reg      <= '0;
         fill_sel_reg <= 1'b1;
         valid_reg    <= 1'b0;
         ready_reg    <= 1'b0;
         count_reg    <= '0;
      end else begin
         state_reg <= state_next;
         ready_reg <= (state_next == RUN);
         valid_reg <= fetch_fire;
         if (fetch_fire) begin
            fill_sel_reg <= !fetch_in_range;
         end
         if (state_reg == CLEAR) begin
            ptr_reg <= ptr_reg + 1'b1;
         end
         if (state_reg != PROG && state_next == PROG) begin
            count_reg <= '0;
         end else if (state_reg == PROG && LOAD_WE && load_in_range &&
                      count_reg != COUNT_MAX) begin
            count_reg <= count_reg + 1'b1;
         end
      end
   end

   imem_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk   (CLK),
      .we    (mem_we),
      .waddr (mem_waddr),
      .wdata (mem_wdata),
      .re    (mem_re),
      .raddr (FETCH_ADDR),
      .rdata (mem_rdata)
   );

   // Out-of-range fetches and the post-reset value return the fill word.
   assign INSTRUCTION = fill_sel_reg ? FILL_WORD : mem_rdata;
   assign FETCH_VALID = valid_reg;
   assign READY       = ready_reg;
   assign LOAD_COUNT  = count_reg;

endmodule

// File: tb/tb_instr_mem.sv
// Directed bench for instr_mem: a default instance, a DEPTH=200 instance and
// a CLEAR_ON_RESET=0 instance share one stimulus set.
module tb_instr_mem;

   localparam logic [20:0] FILL = 21'h1C0009;

   logic        clk;
   logic        rst_n;
   logic        fetch_req;
   logic [7:0]  fetch_addr;
   logic        prog_mode;
   logic        load_we;
   logic [7:0]  load_addr;
   logic [20:0] load_data;

   logic [20:0] instr_a, instr_b, instr_c;
   logic        valid_a, valid_b, valid_c;
   logic        ready_a, ready_b, ready_c;
   logic [8:0]  count_a, count_b, count_c;

   int n_vec = 0;
   int n_err = 0;

   instr_mem dut (
      .CLK(clk), .RST_N(rst_n), .FETCH_REQ(fetch_req), .FETCH_ADDR(fetch_addr),
      .INSTRUCTION(instr_a), .FETCH_VALID(valid_a), .READY(ready_a),
      .PROG_MODE(prog_mode), .LOAD_WE(load_we), .LOAD_ADDR(load_addr),
      .LOAD_DATA(load_data), .LOAD_COUNT(count_a)
   );

   instr_mem #(.DEPTH(200)) dut200 (
      .CLK(clk), .RST_N(rst_n), .FETCH_REQ(fetch_req), .FETCH_ADDR(fetch_addr),
      .INSTRUCTION(instr_b), .FETCH_VALID(valid_b), .READY(ready_b),
      .PROG_MODE(prog_mode), .LOAD_WE(load_we), .LOAD_ADDR(load_addr),
      .LOAD_DATA(load_data), .LOAD_COUNT(count_b)
   );

   instr_mem #(.CLEAR_ON_RESET(1'b0)) dut_nc (
      .CLK(clk), .RST_N(rst_n), .FETCH_REQ(fetch_req), .FETCH_ADDR(fetch_addr),
      .INSTRUCTION(instr_c), .FETCH_VALID(valid_c), .READY(ready_c),
      .PROG_MODE(prog_mode), .LOAD_WE(load_we), .LOAD_ADDR(load_addr),
      .LOAD_DATA(load_data), .LOAD_COUNT(count_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        pm;
      logic        we;
      logic [7:0]  la;
      logic [20:0] ld;
      logic        req;
      logic [7:0]  fa;
      logic        exp_ready;
      logic        exp_valid;
      logic [20:0] exp_instr;
      logic [8:0]  exp_count;
   } vec_t;

   vec_t tbl [17];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle();
      fetch_req = 1'b0; fetch_addr = 8'h00;
      load_we = 1'b0; load_addr = 8'h00; load_data = 21'h0;
   endtask

   initial begin
      // Load/fetch session on the default instance; expectations after the edge.
      tbl[0]  = '{1'b1, 1'b0, 8'h00, 21'h000000, 1'b0, 8'h00, 1'b0, 1'b0, FILL,        9'd0};
      tbl[1]  = '{1'b1, 1'b1, 8'h00, 21'h05C000, 1'b0, 8'h00, 1'b0, 1'b0, FILL,        9'd1};
      tbl[2]  = '{1'b1, 1'b1, 8'h01, 21'h060000, 1'b0, 8'h00, 1'b0, 1'b0, FILL,        9'd2};
      tbl[3]  = '{1'b0, 1'b1, 8'h02, 21'h1D8301, 1'b1, 8'h00, 1'b1, 1'b0, FILL,        9'd3};
      tbl[4]  = '{1'b0, 1'b0, 8'h00, 21'h000000, 1'b1, 8'h00, 1'b1, 1'b1, 21'h05C000,  9'd3};
      tbl[5]  = '{1'b0, 1'b0, 8'h00, 21'h000000, 1'b1, 8'h01, 1'b1, 1'b1, 21'h060000,  9'd3};
      tbl[6]  = '{1'b0, 1'b0, 8'h00, 21'h000000, 1'b1, 8'h02, 1'b1, 1'b1, 21'h1D8301,  9'd3};
      tbl[7]  = '{1'b1, 1'b0, 8'h00, 21'h000000, 1'b1, 8'h01, 1'b0, 1'b1, 21'h060000,  9'd0};
      tbl[8]  = '{1'b1, 1'b0, 8'h00, 21'h000000, 1'b1, 8'h02, 1'b0, 1'b0, 21'h060000,  9'd0};
      tbl[9]  = '{1'b0, 1'b0, 8'h00, 21'h000000, 1'b0, 8'h00, 1'b1, 1'b0, 21'h060000,  9'd0};
      tbl[10] = '{1'b0, 1'b0, 8'h00, 21'h000000, 1'b0, 8'h00, 1'b1, 1'b0, 21'h060000,  9'd0};
      tbl[11] = '{1'b1, 1'b0, 8'h00, 21'h000000, 1'b0, 8'h00, 1'b0, 1'b0, 21'h060000,  9'd0};
      tbl[12] = '{1'b1, 1'b1, 8'h00, 21'h000001, 1'b0, 8'h00, 1'b0, 1'b0, 21'h060000,  9'd1};
      tbl[13] = '{1'b1, 1'b1, 8'h00, 21'h0ABCDE, 1'b0, 8'h00, 1'b0, 1'b0, 21'h060000,  9'd2};
      tbl[14] = '{1'b0, 1'b0, 8'h00, 21'h000000, 1'b0, 8'h00, 1'b1, 1'b0, 21'h060000,  9'd2};
      tbl[15] = '{1'b0, 1'b0, 8'h00, 21'h000000, 1'b1, 8'h00, 1'b1, 1'b1, 21'h0ABCDE,  9'd2};
      tbl[16] = '{1'b0, 1'b0, 8'h00, 21'h000000, 1'b0, 8'h00, 1'b1, 1'b0, 21'h0ABCDE,  9'd2};

      // Reset state
      rst_n = 1'b0; prog_mode = 1'b0; idle();
      step(); step();
      chk("reset_instr", 32'(instr_a), 32'(FILL));
      chk("reset_valid", 32'(valid_a), 32'd0);
      chk("reset_ready", 32'(ready_a), 32'd0);
      chk("reset_count", 32'(count_a), 32'd0);
      chk("reset_ready_nc", 32'(ready_c), 32'd0);
      $display("reset state checked");

      // Sweep length: 256 edges for the default, 200 for DEPTH=200, none without clear
      rst_n = 1'b1;
      for (int i = 1; i <= 256; i++) begin
         step();
         if (i == 1) begin
            chk("nc_ready_after_release", 32'(ready_c), 32'd1);
            chk("sweep_ready_c1", 32'(ready_a), 32'd0);
         end
         if (i == 199) chk("sweep200_ready_199", 32'(ready_b), 32'd0);
         if (i == 200) chk("sweep200_ready_200", 32'(ready_b), 32'd1);
         if (i == 255) chk("sweep_ready_255", 32'(ready_a), 32'd0);
         if (i == 256) chk("sweep_ready_256", 32'(ready_a), 32'd1);
      end
      $display("sweep done, READY=%0d", ready_a);

      // Fetches of cleared locations
      fetch_req = 1'b1; fetch_addr = 8'h05;
      step();
      chk("fetch05_valid", 32'(valid_a), 32'd1);
      chk("fetch05_instr", 32'(instr_a), 32'(FILL));
      fetch_addr = 8'hFF;
      step();
      chk("fetchFF_valid", 32'(valid_a), 32'd1);
      chk("fetchFF_instr", 32'(instr_a), 32'(FILL));
      $display("cleared fetches instr=%h", instr_a);

      // Table-driven load/fetch session
      for (int v = 0; v < 17; v++) begin
         prog_mode  = tbl[v].pm;
         load_we    = tbl[v].we;
         load_addr  = tbl[v].la;
         load_data  = tbl[v].ld;
         fetch_req  = tbl[v].req;
         fetch_addr = tbl[v].fa;
         step();
         chk($sformatf("vec%0d_ready", v), 32'(ready_a), 32'(tbl[v].exp_ready));
         chk($sformatf("vec%0d_valid", v), 32'(valid_a), 32'(tbl[v].exp_valid));
         chk($sformatf("vec%0d_instr", v), 32'(instr_a), 32'(tbl[v].exp_instr));
         chk($sformatf("vec%0d_count", v), 32'(count_a), 32'(tbl[v].exp_count));
         $display("vec %0d: ready=%0d valid=%0d instr=%h count=%0d",
                  v, ready_a, valid_a, instr_a, count_a);
      end

      // DEPTH=200 boundary: 0xC8 is out of range there, in range at DEPTH=256
      idle(); prog_mode = 1'b1;
      step();
      chk("d200_entry_count", 32'(count_b), 32'd0);
      load_we = 1'b1; load_addr = 8'hC8; load_data = 21'h012345;
      step();
      chk("d200_drop_count", 32'(count_b), 32'd0);
      chk("d256_C8_count", 32'(count_a), 32'd1);
      load_addr = 8'hC7; load_data = 21'h0F0F0F;
      step();
      chk("d200_C7_count", 32'(count_b), 32'd1);
      chk("d256_C7_count", 32'(count_a), 32'd2);
      idle(); prog_mode = 1'b0;
      step();
      chk("d200_ready", 32'(ready_b), 32'd1);
      fetch_req = 1'b1; fetch_addr = 8'hC8;
      step();
      chk("d200_C8_valid", 32'(valid_b), 32'd1);
      chk("d200_C8_instr", 32'(instr_b), 32'(FILL));
      chk("d256_C8_instr", 32'(instr_a), 32'h012345);
      fetch_addr = 8'hC7;
      step();
      chk("d200_C7_instr", 32'(instr_b), 32'h0F0F0F);
      $display("depth200 boundary: C7=%h", instr_b);

      // Load counter saturation at 511
      idle(); prog_mode = 1'b1;
      step();
      load_we = 1'b1; load_addr = 8'h10; load_data = 21'h000010;
      for (int i = 1; i <= 512; i++) begin
         step();
         if (i == 510) chk("sat_510", 32'(count_a), 32'd510);
         if (i == 511) chk("sat_511", 32'(count_a), 32'd511);
         if (i == 512) chk("sat_512", 32'(count_a), 32'd511);
      end
      idle(); prog_mode = 1'b0;
      step();
      $display("saturation: count=%0d", count_a);

      // Reset in the middle of a load session
      prog_mode = 1'b1;
      step();
      load_we = 1'b1; load_addr = 8'h01; load_data = 21'h111111;
      step();
      load_addr = 8'h03; load_data = 21'h333333;
      step();
      chk("midload_count", 32'(count_a), 32'd2);
      load_addr = 8'h04; load_data = 21'h444444; rst_n = 1'b0;
      step();
      chk("midload_rst_ready", 32'(ready_a), 32'd0);
      chk("midload_rst_count", 32'(count_a), 32'd0);
      chk("midload_rst_valid", 32'(valid_a), 32'd0);
      chk("midload_rst_instr", 32'(instr_a), 32'(FILL));
      rst_n = 1'b1; prog_mode = 1'b0; idle();
      for (int i = 1; i <= 256; i++) step();
      chk("midload_resweep_ready", 32'(ready_a), 32'd1);
      fetch_req = 1'b1; fetch_addr = 8'h01;
      step();
      chk("midload_addr1_valid", 32'(valid_a), 32'd1);
      chk("midload_addr1_instr", 32'(instr_a), 32'(FILL));
      $display("reset mid-load: addr1=%h", instr_a);

      // PROG_MODE held through the sweep enters PROG directly
      idle(); rst_n = 1'b0; prog_mode = 1'b1;
      step();
      rst_n = 1'b1;
      for (int i = 1; i <= 256; i++) begin
         step();
         chk($sformatf("progsweep_ready_%0d", i), 32'(ready_a), 32'd0);
      end
      load_we = 1'b1; load_addr = 8'h05; load_data = 21'h055555;
      step();
      chk("progsweep_count", 32'(count_a), 32'd1);
      chk("progsweep_ready_after", 32'(ready_a), 32'd0);
      idle(); prog_mode = 1'b0;
      step();
      chk("progsweep_exit_ready", 32'(ready_a), 32'd1);
      fetch_req = 1'b1; fetch_addr = 8'h05;
      step();
      chk("progsweep_fetch_valid", 32'(valid_a), 32'd1);
      chk("progsweep_fetch_instr", 32'(instr_a), 32'h055555);
      $display("prog after sweep: addr5=%h", instr_a);
      idle();
      step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
